// File: rtl/pipeline_exmem_stage_if.sv
// pipeline_exmem_stage_if
// Bundles every non-clock, non-reset signal of the EX/MEM pipeline stage.
//   slave  : the stage's view. It takes in execute-stage control and data,
//            the hazard-unit enable and flush, and the data-memory completion.
//            It drives the memory request, the latched copies, the stall and
//            the forwarding source.
//   master : the surrounding pipeline's view, with every direction reversed.
interface pipeline_exmem_stage_if;
  // hazard unit
  logic        en;
  logic        sRST;
  logic        mem_stall;
  // execute-stage control
  logic [4:0]  wsel;
  logic        regen;
  logic [1:0]  regsrc;
  logic        hlt;
  logic        dmemWEN;
  logic        dmemREN;
  // execute-stage data
  logic [31:0] aluout;
  logic [31:0] rdat2;
  logic [31:0] extimm;
  logic [31:0] rtnaddr;
  // data memory
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dREN;
  logic        dWEN;
  logic        dhit;
  logic [31:0] dmemload;
  // latched copies for the writeback stage
  logic [4:0]  wsel_l;
  logic        regen_l;
  logic [1:0]  regsrc_l;
  logic        hlt_l;
  logic [31:0] aluout_l;
  logic [31:0] extimm_l;
  logic [31:0] rtnaddr_l;
  logic [31:0] memload_l;
  // forwarding source
  logic        fwd_valid;
  logic [4:0]  fwd_wsel;
  logic [31:0] fwd_data;

  modport slave (
    input  en, sRST, wsel, regen, regsrc, hlt, dmemWEN, dmemREN,
           aluout, rdat2, extimm, rtnaddr, dhit, dmemload,
    output dmemaddr, dmemstore, dREN, dWEN, wsel_l, regen_l, regsrc_l,
           hlt_l, aluout_l, extimm_l, rtnaddr_l, memload_l, mem_stall,
           fwd_valid, fwd_wsel, fwd_data
  );

  modport master (
    output en, sRST, wsel, regen, regsrc, hlt, dmemWEN, dmemREN,
           aluout, rdat2, extimm, rtnaddr, dhit, dmemload,
    input  dmemaddr, dmemstore, dREN, dWEN, wsel_l, regen_l, regsrc_l,
           hlt_l, aluout_l, extimm_l, rtnaddr_l, memload_l, mem_stall,
           fwd_valid, fwd_wsel, fwd_data
  );
endinterface

// File: rtl/pipeline_exmem_stage.sv
// pipeline_exmem_stage
// EX/MEM pipeline register with a data-memory request FSM (IDLE, REQ, DONE).
// Execute-stage values are latched when the stage advances. A latched load or
// store holds the stage in REQ, with mem_stall raised, until dhit arrives.
// Ports:
//   CLK   : clock; all state changes on the rising edge
//   nRST  : asynchronous active-low reset
//   bus   : pipeline_exmem_stage_if.slave, which carries control, data,
//           the memory request, the latched copies, the stall and forwarding
// Optional feature: define EXMEM_FWD_EN to drive the forwarding outputs.
// Without it, fwd_valid, fwd_wsel and fwd_data are tied to zero.
module pipeline_exmem_stage (
  input logic                  CLK,
  input logic                  nRST,
  pipeline_exmem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  wsel;
    logic        regen;
    logic [1:0]  regsrc;
    logic        hlt;
    logic        dmemwen;
    logic        dmemren;
    logic [31:0] aluout;
    logic [31:0] rdat2;
    logic [31:0] extimm;
    logic [31:0] rtnaddr;
  } lat_t;

  state_t      state_q, state_d;
  lat_t        lat_q, lat_d;
  logic [31:0] memload_q, memload_d;

  logic in_req;
  logic rd_issue;
  logic wr_issue;

  // A store wins over a load when both are latched. A halted instruction
  // never reaches REQ, but the hlt gate keeps the request outputs safe anyway.
  assign in_req   = (state_q == REQ);
  assign wr_issue = in_req & lat_q.dmemwen & ~lat_q.hlt;
  assign rd_issue = in_req & lat_q.dmemren & ~lat_q.dmemwen & ~lat_q.hlt;

  // State register. Reset abandons any in-flight request immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      memload_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      memload_q <= memload_d;
    end
  end

  // Next state and register updates. While in REQ, the stage ignores both the
  // flush and the enable until memory answers. Outside REQ, a flush beats an
  // advance.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    memload_d = memload_q;
    case (state_q)
      REQ: begin
        if (bus.dhit) begin
          state_d = DONE;
          if (rd_issue) begin
            memload_d = bus.dmemload;
          end
        end
      end
      default: begin
        if (bus.sRST) begin
          state_d   = IDLE;
          lat_d     = '0;
          memload_d = '0;
        end else if (bus.en) begin
          lat_d.wsel    = bus.wsel;
          lat_d.regen   = bus.regen;
          lat_d.regsrc  = bus.regsrc;
          lat_d.hlt     = bus.hlt;
          lat_d.dmemwen = bus.dmemWEN;
          lat_d.dmemren = bus.dmemREN;
          lat_d.aluout  = bus.aluout;
          lat_d.rdat2   = bus.rdat2;
          lat_d.extimm  = bus.extimm;
          lat_d.rtnaddr = bus.rtnaddr;
          // A halted instruction makes no memory access, so it must not wait
          // for a dhit that will never come.
          state_d = ((bus.dmemREN | bus.dmemWEN) & ~bus.hlt) ? REQ : IDLE;
        end
      end
    endcase
  end

  assign bus.dREN      = rd_issue;
  assign bus.dWEN      = wr_issue;
  assign bus.dmemaddr  = in_req ? lat_q.aluout : '0;
  assign bus.dmemstore = in_req ? lat_q.rdat2  : '0;
  assign bus.mem_stall = in_req;

  assign bus.wsel_l    = lat_q.wsel;
  assign bus.regen_l   = lat_q.regen;
  assign bus.regsrc_l  = lat_q.regsrc;
  assign bus.hlt_l     = lat_q.hlt;
  assign bus.aluout_l  = lat_q.aluout;
  assign bus.extimm_l  = lat_q.extimm;
  assign bus.rtnaddr_l = lat_q.rtnaddr;
  assign bus.memload_l = memload_q;

`ifdef EXMEM_FWD_EN
  // regsrc value 1 selects memory-load data for writeback.
  localparam logic [1:0] REGSRC_MEM = 2'd1;

  assign bus.fwd_valid = lat_q.regen & (lat_q.wsel != 5'd0) & ~in_req;
  assign bus.fwd_wsel  = lat_q.wsel;
  assign bus.fwd_data  = (lat_q.regsrc == REGSRC_MEM) ? memload_q : lat_q.aluout;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_wsel  = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pipeline_exmem_stage.sv
// tb_pipeline_exmem_stage
// Self-checking bench for pipeline_exmem_stage. A transaction-level model
// tracks what the stage holds and whether it is waiting on memory. Every
// falling edge, all outputs are compared against that model. Directed
// scenarios add hand-computed literal checks that pin the model.
// Honours EXMEM_FWD_EN in the same way as the design.
module tb_pipeline_exmem_stage;

  logic CLK;
  logic nRST;
  int   testCount = 0;
  int   failCount = 0;

  pipeline_exmem_stage_if bus();

  pipeline_exmem_stage dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: the captured instruction, a flag for an outstanding
  // memory access, and the last loaded word.
  typedef struct packed {
    logic [4:0]  wsel;
    logic        regen;
    logic [1:0]  regsrc;
    logic        hlt;
    logic        wen;
    logic        ren;
    logic [31:0] aluout;
    logic [31:0] rdat2;
    logic [31:0] extimm;
    logic [31:0] rtnaddr;
  } instr_t;

  instr_t      m;
  logic        mWait;
  logic [31:0] mLoad;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m     = '0;
      mWait = 1'b0;
      mLoad = '0;
    end else if (mWait) begin
      if (bus.dhit) begin
        mWait = 1'b0;
        if (m.ren && !m.wen) mLoad = bus.dmemload;
      end
    end else if (bus.sRST) begin
      m     = '0;
      mLoad = '0;
    end else if (bus.en) begin
      m.wsel    = bus.wsel;
      m.regen   = bus.regen;
      m.regsrc  = bus.regsrc;
      m.hlt     = bus.hlt;
      m.wen     = bus.dmemWEN;
      m.ren     = bus.dmemREN;
      m.aluout  = bus.aluout;
      m.rdat2   = bus.rdat2;
      m.extimm  = bus.extimm;
      m.rtnaddr = bus.rtnaddr;
      mWait     = (bus.dmemREN || bus.dmemWEN) && !bus.hlt;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every output against the model each cycle.
  always @(negedge CLK) begin
    if (nRST) begin
      checkOutput("cmp dREN", 32'(bus.dREN), 32'(mWait && m.ren && !m.wen));
      checkOutput("cmp dWEN", 32'(bus.dWEN), 32'(mWait && m.wen));
      checkOutput("cmp dmemaddr", bus.dmemaddr, mWait ? m.aluout : 32'h0);
      checkOutput("cmp dmemstore", bus.dmemstore, mWait ? m.rdat2 : 32'h0);
      checkOutput("cmp mem_stall", 32'(bus.mem_stall), 32'(mWait));
      checkOutput("cmp wsel_l", 32'(bus.wsel_l), 32'(m.wsel));
      checkOutput("cmp regen_l", 32'(bus.regen_l), 32'(m.regen));
      checkOutput("cmp regsrc_l", 32'(bus.regsrc_l), 32'(m.regsrc));
      checkOutput("cmp hlt_l", 32'(bus.hlt_l), 32'(m.hlt));
      checkOutput("cmp aluout_l", bus.aluout_l, m.aluout);
      checkOutput("cmp extimm_l", bus.extimm_l, m.extimm);
      checkOutput("cmp rtnaddr_l", bus.rtnaddr_l, m.rtnaddr);
      checkOutput("cmp memload_l", bus.memload_l, mLoad);
`ifdef EXMEM_FWD_EN
      checkOutput("cmp fwd_valid", 32'(bus.fwd_valid),
                  32'(m.regen && (m.wsel != 5'd0) && !mWait));
      checkOutput("cmp fwd_wsel", 32'(bus.fwd_wsel), 32'(m.wsel));
      checkOutput("cmp fwd_data", bus.fwd_data, (m.regsrc == 2'd1) ? mLoad : m.aluout);
`else
      checkOutput("cmp fwd_valid", 32'(bus.fwd_valid), 32'h0);
      checkOutput("cmp fwd_wsel", 32'(bus.fwd_wsel), 32'h0);
      checkOutput("cmp fwd_data", bus.fwd_data, 32'h0);
`endif
    end
  end

  task automatic applyStimulus(input logic en, input logic srst, input logic [4:0] wsel,
                               input logic regen, input logic [1:0] regsrc,
                               input logic hlt, input logic ren, input logic wen,
                               input logic [31:0] aluout, input logic [31:0] rdat2);
    bus.en      = en;
    bus.sRST    = srst;
    bus.wsel    = wsel;
    bus.regen   = regen;
    bus.regsrc  = regsrc;
    bus.hlt     = hlt;
    bus.dmemREN = ren;
    bus.dmemWEN = wen;
    bus.aluout  = aluout;
    bus.rdat2   = rdat2;
    bus.extimm  = aluout ^ 32'h0F0F_0000;
    bus.rtnaddr = aluout + 32'd4;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdCount;
    int stallCount;
    int wrCount;

    nRST         = 1'b0;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    checkOutput("reset aluout_l", bus.aluout_l, 32'h0);
    checkOutput("reset dREN", 32'(bus.dREN), 32'h0);
    checkOutput("reset mem_stall", 32'(bus.mem_stall), 32'h0);
    checkOutput("reset fwd_valid", 32'(bus.fwd_valid), 32'h0);

    // Plain ALU instruction, no memory access
    applyStimulus(1, 0, 5, 1, 0, 0, 0, 0, 32'h1234, 32'h0);
    @(negedge CLK);
    bus.en = 1'b0;
    checkOutput("alu aluout_l", bus.aluout_l, 32'h1234);
    checkOutput("alu wsel_l", 32'(bus.wsel_l), 32'd5);
    checkOutput("alu mem_stall", 32'(bus.mem_stall), 32'h0);

    // With enable low, the latched values must hold
    bus.aluout = 32'hFFFF;
    @(negedge CLK);
    checkOutput("hold aluout_l", bus.aluout_l, 32'h1234);

    // Halted load: no request and no stall
    applyStimulus(1, 0, 7, 1, 0, 1, 1, 0, 32'h400, 32'h0);
    @(negedge CLK);
    bus.en = 1'b0;
    checkOutput("hlt dREN", 32'(bus.dREN), 32'h0);
    checkOutput("hlt mem_stall", 32'(bus.mem_stall), 32'h0);
    checkOutput("hlt hlt_l", 32'(bus.hlt_l), 32'h1);

    // Load and store both set: only the write is issued
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h500, 32'h77);
    bus.dhit = 1'b1;
    @(negedge CLK);
    bus.en = 1'b0;
    checkOutput("both dWEN", 32'(bus.dWEN), 32'h1);
    checkOutput("both dREN", 32'(bus.dREN), 32'h0);
    checkOutput("both dmemstore", bus.dmemstore, 32'h77);
    @(negedge CLK);
    bus.dhit = 1'b0;
    checkOutput("both stall done", 32'(bus.mem_stall), 32'h0);

    // Load that waits three cycles for memory
    applyStimulus(1, 0, 9, 1, 1, 0, 1, 0, 32'h100, 32'h0);
    @(negedge CLK);
    bus.en = 1'b0;
    rdCount = 0;
    stallCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dREN && bus.dmemaddr == 32'h100) rdCount++;
      if (bus.mem_stall) stallCount++;
      bus.dhit     = (i == 3);
      bus.dmemload = 32'hDEADBEEF;
      @(negedge CLK);
    end
    bus.dhit = 1'b0;
    checkOutput("load dREN cycles", 32'(rdCount), 32'd4);
    checkOutput("load stall cycles", 32'(stallCount), 32'd4);
    checkOutput("load memload_l", bus.memload_l, 32'hDEADBEEF);
    checkOutput("load dREN after", 32'(bus.dREN), 32'h0);
`ifdef EXMEM_FWD_EN
    checkOutput("load fwd_data", bus.fwd_data, 32'hDEADBEEF);
    checkOutput("load fwd_valid", 32'(bus.fwd_valid), 32'h1);
`endif

    // Store answered in the same cycle it is issued
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 32'hCAFE);
    bus.dhit = 1'b1;
    @(negedge CLK);
    bus.en = 1'b0;
    wrCount = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.dWEN) wrCount++;
      if (i == 0) begin
        checkOutput("store dmemstore", bus.dmemstore, 32'hCAFE);
        checkOutput("store dmemaddr", bus.dmemaddr, 32'h200);
      end
      @(negedge CLK);
    end
    bus.dhit = 1'b0;
    checkOutput("store dWEN cycles", 32'(wrCount), 32'd1);
    checkOutput("store stall after", 32'(bus.mem_stall), 32'h0);

    // A flush is ignored during REQ and takes effect once the access is done
    applyStimulus(1, 0, 4, 1, 0, 0, 1, 0, 32'h300, 32'h0);
    @(negedge CLK);
    bus.en   = 1'b0;
    bus.sRST = 1'b1;
    @(negedge CLK);
    checkOutput("srst req stall", 32'(bus.mem_stall), 32'h1);
    checkOutput("srst req aluout_l", bus.aluout_l, 32'h300);
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h55;
    @(negedge CLK);
    bus.dhit = 1'b0;
    checkOutput("srst done memload_l", bus.memload_l, 32'h55);
    checkOutput("srst done aluout_l", bus.aluout_l, 32'h300);
    @(negedge CLK);
    checkOutput("srst flush aluout_l", bus.aluout_l, 32'h0);
    checkOutput("srst flush memload_l", bus.memload_l, 32'h0);
    checkOutput("srst flush regen_l", 32'(bus.regen_l), 32'h0);

    // A flush takes priority over the enable
    applyStimulus(1, 1, 2, 1, 0, 0, 0, 0, 32'h999, 32'h0);
    @(negedge CLK);
    checkOutput("srst over en", bus.aluout_l, 32'h0);
    bus.sRST = 1'b0;
    bus.en   = 1'b0;
    @(negedge CLK);

    // Forwarding source for a zero and a nonzero destination register
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 32'h600, 32'h0);
    @(negedge CLK);
    bus.en = 1'b0;
    checkOutput("fwd wsel0 valid", 32'(bus.fwd_valid), 32'h0);
    applyStimulus(1, 0, 3, 1, 0, 0, 0, 0, 32'h700, 32'h0);
    @(negedge CLK);
    bus.en = 1'b0;
`ifdef EXMEM_FWD_EN
    checkOutput("fwd wsel3 valid", 32'(bus.fwd_valid), 32'h1);
    checkOutput("fwd wsel3 wsel", 32'(bus.fwd_wsel), 32'd3);
    checkOutput("fwd wsel3 data", bus.fwd_data, 32'h700);
`else
    checkOutput("fwd tied valid", 32'(bus.fwd_valid), 32'h0);
    checkOutput("fwd tied data", bus.fwd_data, 32'h0);
`endif

    // Reset in the middle of REQ abandons the request at once
    applyStimulus(1, 0, 6, 1, 0, 0, 1, 0, 32'h800, 32'h0);
    bus.dhit = 1'b0;
    @(negedge CLK);
    bus.en = 1'b0;
    checkOutput("rst pre dREN", 32'(bus.dREN), 32'h1);
    #2 nRST = 1'b0;
    #1;
    checkOutput("rst mid dREN", 32'(bus.dREN), 32'h0);
    checkOutput("rst mid stall", 32'(bus.mem_stall), 32'h0);
    checkOutput("rst mid aluout_l", bus.aluout_l, 32'h0);
    checkOutput("rst mid dmemaddr", bus.dmemaddr, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("rst after dREN", 32'(bus.dREN), 32'h0);
    checkOutput("rst after stall", 32'(bus.mem_stall), 32'h0);
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
